// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin N-way mux and its arbiter.
package mux_pkg;

  // Operating mode of the mux: fixed channel select or round-robin arbitration.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_t;

  // Ceiling log2, used to size channel index fields (value >= 2 expected).
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational rotate-priority encoder: picks the first requesting channel
// strictly after 'last', wrapping from WAYS-1 back to 0.
module rr_arbiter_n
  import mux_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int SEL_W = clog2(WAYS)
) (
  input  logic [WAYS-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);

  // Walk the channels in priority order starting just after the last winner;
  // the first requester seen wins and later candidates are ignored.
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= WAYS; k++) begin
      cand = (int'(last) + k) % WAYS;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux_n_way.sv
// N-way valid/ready mux onto a single registered output channel, with either a
// fixed channel select or round-robin arbitration between the inputs.
module rr_mux_n_way
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [WAYS-1:0]         in_valid,
  output logic [WAYS-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
);

  logic             loadEn;
  logic             fixedValid;
  logic             arbValid;
  logic [SEL_W-1:0] arbIdx;
  logic             grantValid;
  logic [SEL_W-1:0] grantIdx;
  logic [WIDTH-1:0] grantData;
  logic             xfer;
  mode_t            curMode;

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [SEL_W-1:0] outSel_q, outSel_d;
  logic             outValid_q, outValid_d;
  logic [SEL_W-1:0] lastPtr_q, lastPtr_d;

  assign curMode = mode_t'(mode);

  // The output stage can take a word when empty or when it drains this cycle.
  assign loadEn = !outValid_q || out_ready;

  rr_arbiter_n #(
    .WAYS  (WAYS),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .req         (in_valid),
    .last        (lastPtr_q),
    .grant_valid (arbValid),
    .grant_idx   (arbIdx)
  );

  // Choose the granted channel: the selected one in fixed mode (only if it is
  // valid and in range), otherwise whatever the rotating arbiter picked.
  always_comb begin
    fixedValid = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (sel == SEL_W'(i)) begin
        fixedValid = in_valid[i];
      end
    end
    if (curMode == MODE_RR) begin
      grantValid = arbValid;
      grantIdx   = arbIdx;
    end else begin
      grantValid = fixedValid;
      grantIdx   = sel;
    end
  end

  // Steer the granted lane's data and raise exactly one ready; nothing is
  // accepted while reset is held so no word slips in during the reset cycle.
  always_comb begin
    grantData = '0;
    in_ready  = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grantIdx == SEL_W'(i)) begin
        grantData   = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !reset && loadEn && grantValid;
      end
    end
  end

  assign xfer = !reset && loadEn && grantValid;

  // Next-state for the output register and round-robin pointer: load on a
  // transfer (refill wins over drain), otherwise empty the stage on drain.
  always_comb begin
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    lastPtr_d  = lastPtr_q;
    if (xfer) begin
      outData_d  = grantData;
      outSel_d   = grantIdx;
      outValid_d = 1'b1;
      if (curMode == MODE_RR) begin
        lastPtr_d = grantIdx;
      end
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to the top channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
      lastPtr_q  <= SEL_W'(WAYS - 1);
    end else begin
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
      lastPtr_q  <= lastPtr_d;
    end
  end

  assign out_data  = outData_q;
  assign out_sel   = outSel_q;
  assign out_valid = outValid_q;

endmodule

// File: doc/rr_mux_n_way.md
Name: rr_mux_n_way

Overview:
- Parametrised successor to the combinational 8-way/16-bit mux: WAYS input channels of WIDTH bits, each with a valid/ready handshake, merged onto one registered output channel.
- Two modes: fixed select (sel input chooses the channel, registered mux) and round-robin arbitration.
- Used wherever several producers share one 16-bit consumer, e.g. CPU and video fetch sharing a RAM port.

Parameters:
- WIDTH, 16, data width per channel.
- WAYS, 8, number of input channels (2..16).
- SEL_W, $clog2(WAYS), select/index width. Derived; do not override.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WAYS*WIDTH  packed inputs; channel i at [i*WIDTH +: WIDTH].
- in_valid  in  WAYS  per-channel valid.
- in_ready  out  WAYS  per-channel ready (combinational); at most one bit set.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel chosen in fixed mode; ignored in round-robin mode.
- out_data  out  WIDTH  registered output word.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.
- out_sel  out  SEL_W  source channel of the current out_data.

Behaviour:
- Reset is synchronous and active-high on clk; there is one clock.
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - RR pointer last = WAYS-1, so channel 0 has top priority after reset.
- load_en = !out_valid || out_ready. This makes the output register a single-stage pipeline with full throughput (1 word/cycle).
- Grant:
  - Fixed mode: g = sel if in_valid[sel], else no grant. Other channels are never granted. sel >= WAYS gives no grant.
  - RR mode: g = the first i with in_valid[i], searching from last+1 upward and wrapping at WAYS-1 -> 0. No valid channels gives no grant.
- in_ready[i] = load_en && granted && (i == g). in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready.
- Transfer on an input edge (in_valid[g] && in_ready[g]):
  - out_data <= in_data[g*WIDTH +: WIDTH].
  - out_sel <= g.
  - out_valid <= 1.
  - In RR mode, last <= g.
- Latency: a word is visible on out_data exactly 1 cycle after its input handshake.
- Output handshake: if out_valid && out_ready and there is no new grant, out_valid <= 0.
- Same-edge drain and refill: drain and load occur together; out_valid stays 1 and the new word replaces the old.
- Backpressure: while out_valid && !out_ready, all in_ready = 0 and out_data/out_sel are held stable.
- Pointer behaviour:
  - last only updates on an RR-mode transfer.
  - Fixed-mode transfers leave last unchanged.
  - Switching mode takes effect on the next grant evaluation. Any word already held is unaffected.
- Fairness: with all channels continuously valid and out_ready = 1, RR grants 0,1,...,WAYS-1,0,... with no repeats. Worst-case wait for a valid channel is WAYS-1 transfers.
- Reset mid-operation: any held word is discarded without a handshake. Outputs and pointer return to reset values on the next edge. in_ready is 0 during the reset cycle.
- Producers must keep in_data stable while in_valid && !in_ready.

Decomposition:
- Shared package mux_pkg:
  - typedef mode_t (MODE_FIXED = 0, MODE_RR = 1).
  - function clog2 for SEL_W.
- Sub-module rr_arbiter_n:
  - Parameter WAYS.
  - Inputs: req[WAYS], last[SEL_W].
  - Outputs: grant_valid, grant_idx.
  - Purely combinational rotate-priority encoder.
- The pointer register, output register and fixed-mode path stay in rr_mux_n_way.

Test Plan:
1. Fixed mode, WAYS = 8, WIDTH = 16, out_ready = 1, sel = 5, lane 5 = 16'hBEEF, in_valid = 8'hFF -> only in_ready[5] = 1; next cycle out_data = 16'hBEEF, out_sel = 5, out_valid = 1. Follow with 128 random in/sel vectors; every word must equal in[sel*16 +: 16] from the previous cycle.
2. RR mode after reset, in_valid = 8'hFF constant, out_ready = 1 -> out_sel sequence 0,1,2,...,7,0 across consecutive cycles, out_valid held 1.
3. RR mode, in_valid = 8'b0010_0100, last = 2 -> grants alternate 5,2,5,2; then drop in_valid[5] -> grants 2,2,2.
4. Backpressure: word 16'h1234 from ch 3 held, out_ready = 0 for 4 cycles while ch 3 keeps in_valid -> in_ready = 0, out_data = 16'h1234 stable; out_ready = 1 -> next word loads the same cycle it drains.
5. Reset asserted while out_valid = 1 with out_data = 16'hAAAA -> next edge: out_valid = 0, out_data = 0, out_sel = 0; first RR grant afterwards = 0.
6. Fixed mode, sel = 6 but in_valid[6] = 0 while others are valid -> no in_ready set, out_valid goes 0 after the current word drains. Switch mode to 1 -> lowest channel after last is granted next cycle.
